// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int PAT_W      = 7;
    localparam int SEG_W      = 8;

    // BLANK is the dark gap that precedes each digit, DRIVE lights that digit.
    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_t;

    // Active-low one-cold anode vector for the addressed digit.
    function automatic logic [NUM_DIGITS-1:0] anode_cold(input logic [1:0] dig);
        return ~(NUM_DIGITS'(1) << dig);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Scan timing: phase counter, BLANK/DRIVE state and digit index.
// Exposes the registered digit plus a one-cycle lookahead (phase_next,
// dig_next) so the parent can register its outputs aligned with the scan
// state. wrap flags the last DRIVE cycle of digit 3 (the 3 -> 0 wrap).
module scan_timer
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [1:0]  dig_sel,
    output scan_state_t phase_next,
    output logic [1:0]  dig_next,
    output logic        wrap
);

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       dig_reg;

    // Next-state lookahead; disabling parks the scan at BLANK, digit 0, count 0.
    always_comb begin
        phase_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        dig_next   = dig_reg;
        wrap       = 1'b0;
        if (!enable) begin
            phase_next = SCAN_BLANK;
            cnt_next   = '0;
            dig_next   = '0;
        end else if (state_reg == SCAN_BLANK) begin
            if (cnt_reg == BLANK_LAST) begin
                phase_next = SCAN_DRIVE;
                cnt_next   = '0;
            end
        end else if (cnt_reg == DIGIT_LAST) begin
            phase_next = SCAN_BLANK;
            cnt_next   = '0;
            dig_next   = dig_reg + 2'd1;
            wrap       = (dig_reg == 2'd3);
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= SCAN_BLANK;
            cnt_reg   <= '0;
            dig_reg   <= '0;
        end else begin
            state_reg <= phase_next;
            cnt_reg   <= cnt_next;
            dig_reg   <= dig_next;
        end
    end

    assign dig_sel = dig_reg;

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed seven-segment scan controller with a double-buffered
// frame. A producer loads the shadow buffer over valid/ready; the shadow is
// copied into the displayed buffer only at a frame wrap (or while disabled),
// so a frame is never torn.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [27:0] upd_pat,
    input  logic [3:0]  upd_dots,
    output logic [1:0]  dig_sel,
    output logic [7:0]  segments,
    output logic [3:0]  anode_n,
    output logic        frame_done
);

    scan_state_t phase_next;
    logic [1:0]  dig_next;
    logic        wrap;

    scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .dig_sel    (dig_sel),
        .phase_next (phase_next),
        .dig_next   (dig_next),
        .wrap       (wrap)
    );

    logic [NUM_DIGITS*PAT_W-1:0] shadow_pat_reg;
    logic [NUM_DIGITS-1:0]       shadow_dot_reg;
    logic [NUM_DIGITS*PAT_W-1:0] active_pat_reg;
    logic [NUM_DIGITS-1:0]       active_dot_reg;
    logic [NUM_DIGITS*PAT_W-1:0] active_pat_next;
    logic [NUM_DIGITS-1:0]       active_dot_next;
    logic                        pending_reg;

    logic [SEG_W-1:0] seg_word [NUM_DIGITS];
    logic [SEG_W-1:0] segments_reg;
    logic [3:0]       anode_n_reg;
    logic             frame_done_reg;

    logic accept;
    logic boundary;
    logic swap;

    // Every disabled cycle is treated like a frame wrap so a pending frame lands at once.
    assign accept    = upd_valid && !pending_reg;
    assign boundary  = wrap || !enable;
    assign swap      = boundary && pending_reg;
    assign upd_ready = !pending_reg;

    assign active_pat_next = swap ? shadow_pat_reg : active_pat_reg;
    assign active_dot_next = swap ? shadow_dot_reg : active_dot_reg;

    // The output stage looks at the buffer as it will be after this edge.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg_word
            assign seg_word[gi] = {active_pat_next[PAT_W*gi +: PAT_W], active_dot_next[gi]};
        end
    endgenerate

    // Frame buffers and handshake; an accept can only happen while nothing is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_pat_reg <= '0;
            shadow_dot_reg <= '0;
            active_pat_reg <= '0;
            active_dot_reg <= '0;
            pending_reg    <= 1'b0;
        end else begin
            if (accept) begin
                shadow_pat_reg <= upd_pat;
                shadow_dot_reg <= upd_dots;
                pending_reg    <= 1'b1;
            end else if (swap) begin
                pending_reg    <= 1'b0;
            end
            active_pat_reg <= active_pat_next;
            active_dot_reg <= active_dot_next;
        end
    end

    // Registered display outputs, aligned with the scan state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segments_reg   <= '0;
            anode_n_reg    <= 4'hF;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= wrap;
            if (phase_next == SCAN_DRIVE) begin
                segments_reg <= seg_word[dig_next];
                anode_n_reg  <= anode_cold(dig_next);
            end else begin
                segments_reg <= '0;
                anode_n_reg  <= 4'hF;
            end
        end
    end

    assign segments   = segments_reg;
    assign anode_n    = anode_n_reg;
    assign frame_done = frame_done_reg;

endmodule
